// File: rtl/lcd_hd44780_controller.sv
// lcd_hd44780_controller: HD44780 4-bit write-only driver with power-on init and on-demand frame redraw.
// Define LCD_AUTO_REFRESH_EN to redraw continuously instead of waiting for Update.
module lcd_hd44780_controller #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int POWERUP_US = 15000
) (
    input  logic                   Clock_100MHz,
    input  logic                   Clear,
    input  logic [ROWS*COLS*8-1:0] Text,
    input  logic                   Update,
    output logic                   Ready,
    output logic                   Frame_done,
    output logic [7:4]             LCD_DB,
    output logic                   LCD_E,
    output logic                   LCD_RS,
    output logic                   LCD_RW
);
    function automatic int ns2cyc(longint ns);
        return int'((longint'(CLK_HZ) * ns + 999_999_999) / 1_000_000_000);
    endfunction
    localparam int TSU  = ns2cyc(40);
    localparam int TPW  = ns2cyc(230);
    localparam int THD  = ns2cyc(10);
    localparam int TNIB = ns2cyc(1000);
    localparam int TCMD = ns2cyc(40_000);
    localparam int TCLR = ns2cyc(1_640_000);
    localparam int T41  = ns2cyc(4_100_000);
    localparam int T100 = ns2cyc(100_000);
    localparam int TPWR = ns2cyc(longint'(POWERUP_US) * 1000);
    localparam int TM1  = T41 > TCLR ? T41 : TCLR;
    localparam int TMAX = TPWR > TM1 ? TPWR : TM1;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int TW   = ROWS * COLS * 8;
    typedef enum logic [3:0] {
        PWR_WAIT, INIT8_1, INIT8_2, INIT8_3, INIT4, FUNC_SET, ENTRY_MODE,
        DISP_ON, CLEAR_DISP, IDLE, SET_ADDR, WRITE_CHAR, DONE
    } state_t;
    state_t state_q, state_d, nxt;
    logic [1:0] ph_q, ph_d, row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d, step_dly;
    logic [5:0] col_q, col_d;
    logic [TW-1:0] buf_q, buf_d;
    logic e_q, e_d, rs_q, rs_d, ready_q, ready_d, done_q, done_d;
    logic [3:0] db_q, db_d, nib;
    logic [7:0] step_byte, chr;
    logic step_rs, step_nib, last_col, last_row, act, hold, upd;
`ifdef LCD_AUTO_REFRESH_EN
    assign upd = 1'b1 | Update;
`else
    assign upd = Update;
`endif
    assign last_col = col_q == 6'(COLS - 1);
    assign last_row = row_q == 2'(ROWS - 1);
    assign chr = 8'(buf_q >> (8 * (ROWS * COLS - 1 - int'(row_q) * COLS - int'(col_q))));
    always_comb begin
        step_byte = 8'h00;
        step_rs = 1'b0;
        step_nib = 1'b0;
        step_dly = CW'(TCMD);
        nxt = IDLE;
        case (state_q)
            PWR_WAIT:   begin step_dly = CW'(TPWR); nxt = INIT8_1; end
            INIT8_1:    begin step_byte = 8'h30; step_nib = 1'b1; step_dly = CW'(T41); nxt = INIT8_2; end
            INIT8_2:    begin step_byte = 8'h30; step_nib = 1'b1; step_dly = CW'(T100); nxt = INIT8_3; end
            INIT8_3:    begin step_byte = 8'h30; step_nib = 1'b1; nxt = INIT4; end
            INIT4:      begin step_byte = 8'h20; step_nib = 1'b1; nxt = FUNC_SET; end
            FUNC_SET:   begin step_byte = ROWS >= 2 ? 8'h28 : 8'h20; nxt = ENTRY_MODE; end
            ENTRY_MODE: begin step_byte = 8'h06; nxt = DISP_ON; end
            DISP_ON:    begin step_byte = 8'h0C; nxt = CLEAR_DISP; end
            CLEAR_DISP: begin step_byte = 8'h01; step_dly = CW'(TCLR); nxt = IDLE; end
            SET_ADDR:   begin
                step_byte = row_q == 2'd0 ? 8'h80 : row_q == 2'd1 ? 8'hC0 : row_q == 2'd2 ? 8'h94 : 8'hD4;
                nxt = WRITE_CHAR;
            end
            WRITE_CHAR: begin
                step_byte = chr;
                step_rs = 1'b1;
                nxt = !last_col ? WRITE_CHAR : last_row ? DONE : SET_ADDR;
            end
            default: ;
        endcase
    end
    // ph: 0 = high nibble window, 1 = low nibble window, 2 = post-command delay
    always_comb begin
        state_d = state_q;
        ph_d = ph_q;
        cnt_d = cnt_q + 1'b1;
        row_d = row_q;
        col_d = col_q;
        buf_d = buf_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (upd) begin
                state_d = SET_ADDR;
                ph_d = 2'd0;
                row_d = '0;
                col_d = '0;
                buf_d = Text;
            end
        end else if (state_q == DONE) begin
            cnt_d = '0;
            state_d = IDLE;
        end else if (ph_q != 2'd2) begin
            if (cnt_q == CW'(TNIB - 1)) begin
                cnt_d = '0;
                ph_d = (ph_q == 2'd0 && !step_nib) ? 2'd1 : 2'd2;
            end
        end else if (cnt_q == step_dly - 1'b1) begin
            cnt_d = '0;
            ph_d = 2'd0;
            state_d = nxt;
            if (state_q == WRITE_CHAR) begin
                col_d = last_col ? '0 : col_q + 1'b1;
                row_d = last_col ? row_q + 1'b1 : row_q;
            end
        end
    end
    always_comb begin
        nib = ph_q == 2'd1 ? step_byte[3:0] : step_byte[7:4];
        act = ph_q != 2'd2 && state_q != IDLE && state_q != DONE;
        hold = act && cnt_q < CW'(TSU + TPW + THD);
        e_d = act && cnt_q >= CW'(TSU) && cnt_q < CW'(TSU + TPW);
        rs_d = hold && step_rs;
        db_d = hold ? nib : 4'h0;
        ready_d = state_d == IDLE;
        done_d = state_q == DONE;
    end
    always_ff @(posedge Clock_100MHz) begin
        if (Clear) begin
            state_q <= PWR_WAIT;
            ph_q <= 2'd2;
            cnt_q <= '0;
            row_q <= '0;
            col_q <= '0;
            buf_q <= '0;
            e_q <= 1'b0;
            rs_q <= 1'b0;
            db_q <= 4'h0;
            ready_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q <= ph_d;
            cnt_q <= cnt_d;
            row_q <= row_d;
            col_q <= col_d;
            buf_q <= buf_d;
            e_q <= e_d;
            rs_q <= rs_d;
            db_q <= db_d;
            ready_q <= ready_d;
            done_q <= done_d;
        end
    end
    assign Ready = ready_q;
    assign Frame_done = done_q;
    assign LCD_DB = db_q;
    assign LCD_E = e_q;
    assign LCD_RS = rs_q;
    assign LCD_RW = 1'b0;
endmodule

// File: tb/tb_lcd_hd44780_controller.sv
// tb_lcd_hd44780_controller: directed bench for the HD44780 controller, mostly run at 3 MHz
// (TNIB=3, TCMD=120, TCLR=4920, T41=12300, T100=300, power-up 30 cycles) to keep runs short.
module tb_lcd_hd44780_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic m_clr = 1'b1, a_clr = 1'b1, m_upd = 1'b0, f_upd = 1'b0, zero1 = 1'b0;
    logic [255:0] m_text = '0, zero256 = '0;
    logic [127:0] zero128 = '0;
    logic [639:0] f_text = '0;
    logic m_ready, m_fd, m_e, m_rs, m_rw, t_ready, t_fd, t_e, t_rs, t_rw;
    logic f_ready, f_fd, f_e, f_rs, f_rw, o_ready, o_fd, o_e, o_rs, o_rw;
    logic [3:0] m_db, t_db, f_db, o_db;
    int n_chk = 0, n_fail = 0;
    lcd_hd44780_controller #(.CLK_HZ(3_000_000), .COLS(16), .ROWS(2), .POWERUP_US(10)) dut (
        .Clock_100MHz(clk), .Clear(m_clr), .Text(m_text), .Update(m_upd), .Ready(m_ready),
        .Frame_done(m_fd), .LCD_DB(m_db), .LCD_E(m_e), .LCD_RS(m_rs), .LCD_RW(m_rw));
    lcd_hd44780_controller #(.POWERUP_US(10)) dut_t (
        .Clock_100MHz(clk), .Clear(a_clr), .Text(zero256), .Update(zero1), .Ready(t_ready),
        .Frame_done(t_fd), .LCD_DB(t_db), .LCD_E(t_e), .LCD_RS(t_rs), .LCD_RW(t_rw));
    lcd_hd44780_controller #(.CLK_HZ(3_000_000), .COLS(20), .ROWS(4), .POWERUP_US(10)) dut4 (
        .Clock_100MHz(clk), .Clear(a_clr), .Text(f_text), .Update(f_upd), .Ready(f_ready),
        .Frame_done(f_fd), .LCD_DB(f_db), .LCD_E(f_e), .LCD_RS(f_rs), .LCD_RW(f_rw));
    lcd_hd44780_controller #(.CLK_HZ(3_000_000), .COLS(16), .ROWS(1), .POWERUP_US(10)) dut1 (
        .Clock_100MHz(clk), .Clear(a_clr), .Text(zero128), .Update(zero1), .Ready(o_ready),
        .Frame_done(o_fd), .LCD_DB(o_db), .LCD_E(o_e), .LCD_RS(o_rs), .LCD_RW(o_rw));
    localparam logic [4:0] INIT_SEQ [12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                             5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
    localparam logic [7:0] BASE4 [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};
    // E-pulse capture: each rising E records {RS, DB} sampled on the falling clock edge
    logic [4:0] mq[$], q4[$], q1[$];
    int mt[$];
    int cyc = 0, fd_cnt = 0, rw_bad = 0, setup_bad = 0, hold_bad = 0, width_bad = 0, elen = 0;
    logic m_pe = 1'b0, f_pe = 1'b0, o_pe = 1'b0;
    logic [4:0] m_prev = '0, m_rise = '0;
    always @(negedge clk) begin
        cyc++;
        if (m_e && !m_pe) begin
            mq.push_back({m_rs, m_db});
            mt.push_back(cyc);
            if ({m_rs, m_db} !== m_prev) setup_bad++;
            m_rise = {m_rs, m_db};
        end
        if (m_e) elen++;
        else if (m_pe) begin
            if (elen != 1) width_bad++;
            if ({m_rs, m_db} !== m_rise) hold_bad++;
            elen = 0;
        end
        if (f_e && !f_pe) q4.push_back({f_rs, f_db});
        if (o_e && !o_pe) q1.push_back({o_rs, o_db});
        if (m_rw !== 1'b0 || t_rw !== 1'b0 || f_rw !== 1'b0 || o_rw !== 1'b0) rw_bad++;
        if (m_fd === 1'b1) fd_cnt++;
        m_pe = m_e;
        f_pe = f_e;
        o_pe = o_e;
        m_prev = {m_rs, m_db};
    end
    function automatic logic [9:0] exp_pair(string r0, string r1, int i);
        int r = i / 17;
        int c = i % 17 - 1;
        logic [7:0] b = c < 0 ? (r == 0 ? 8'h80 : 8'hC0) : (r == 0 ? r0[c] : r1[c]);
        logic rs = c >= 0;
        return {rs, b[7:4], rs, b[3:0]};
    endfunction
    task automatic test_timing();
        int s = 0, first = 0, high = 0;
        while (t_e !== 1'b1 && s < 1100) begin
            @(negedge clk);
            s++;
            if (first == 0 && t_db !== 4'h0) first = s;
        end
        n_chk++; if (t_e !== 1'b1) begin n_fail++; $display("FAIL timing_e_rise: E=%b after %0d cycles, want 1", t_e, s); end
        n_chk++; if (first < 1000 || first > 1010) begin n_fail++; $display("FAIL timing_powerup: first DB at %0d, want 1000..1010", first); end
        n_chk++; if (s - first !== 4) begin n_fail++; $display("FAIL timing_setup: %0d cycles, want 4", s - first); end
        n_chk++; if ({t_rs, t_db} !== 5'h03) begin n_fail++; $display("FAIL timing_nibble: %h, want 03", {t_rs, t_db}); end
        while (t_e === 1'b1 && high < 100) begin high++; @(negedge clk); end
        n_chk++; if (high !== 23) begin n_fail++; $display("FAIL timing_width: %0d, want 23", high); end
        n_chk++; if (t_db !== 4'h3) begin n_fail++; $display("FAIL timing_hold: DB=%h, want 3", t_db); end
        @(negedge clk);
        n_chk++; if (t_db !== 4'h0) begin n_fail++; $display("FAIL timing_release: DB=%h, want 0", t_db); end
    endtask
    task automatic test_reset();
        m_clr = 1'b1;
        @(negedge clk);
        m_clr = 1'b0;
        n_chk++; if ({m_ready, m_fd, m_e, m_rs, m_db, m_rw} !== 9'h0) begin n_fail++;
            $display("FAIL reset_outputs: %b, want 0", {m_ready, m_fd, m_e, m_rs, m_db, m_rw}); end
        mq.delete();
        mt.delete();
        for (int i = 0; i < 25000 && m_ready !== 1'b1; i++) @(negedge clk);
        n_chk++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready: Ready=%b, want 1", m_ready); end
        n_chk++; if (mq.size() !== 12) begin n_fail++; $display("FAIL init_count: %0d pulses, want 12", mq.size()); end
        for (int i = 0; i < 12 && i < mq.size(); i++) begin
            n_chk++; if (mq[i] !== INIT_SEQ[i]) begin n_fail++; $display("FAIL init_nib%0d: %h, want %h", i, mq[i], INIT_SEQ[i]); end
        end
        if (mt.size() >= 4) begin
            n_chk++; if (mt[1] - mt[0] < 12300) begin n_fail++; $display("FAIL init_gap41: %0d, want >=12300", mt[1] - mt[0]); end
            n_chk++; if (mt[2] - mt[1] < 300) begin n_fail++; $display("FAIL init_gap100: %0d, want >=300", mt[2] - mt[1]); end
            n_chk++; if (mt[3] - mt[2] < 120) begin n_fail++; $display("FAIL init_gap40: %0d, want >=120", mt[3] - mt[2]); end
        end
    endtask
    task automatic test_frame();
        int n = 0;
        m_text = "HELLO WORLD 1234KEYBOARD TEST OK";
        mq.delete();
        @(negedge clk);
        m_upd = 1'b1;
        @(negedge clk);
        m_upd = 1'b0;
        while (m_fd !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
        n_chk++; if (n !== 4285) begin n_fail++; $display("FAIL frame_latency: %0d, want 4285", n); end
        n_chk++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL frame_ready: %b, want 1", m_ready); end
        n_chk++; if (mq.size() !== 68) begin n_fail++; $display("FAIL frame_count: %0d, want 68", mq.size()); end
        for (int i = 0; i < 34 && 2 * i + 1 < mq.size(); i++) begin
            n_chk++; if ({mq[2*i], mq[2*i+1]} !== exp_pair("HELLO WORLD 1234", "KEYBOARD TEST OK", i)) begin n_fail++;
                $display("FAIL frame_byte%0d: %h, want %h", i, {mq[2*i], mq[2*i+1]}, exp_pair("HELLO WORLD 1234", "KEYBOARD TEST OK", i)); end
        end
        @(negedge clk);
        n_chk++; if (m_fd !== 1'b0) begin n_fail++; $display("FAIL frame_done_width: %b, want 0", m_fd); end
    endtask
    task automatic test_busy_update();
        int n = 0, fdc;
        m_text = "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345";
        mq.delete();
        fdc = fd_cnt;
        @(negedge clk);
        m_upd = 1'b1;
        @(negedge clk);
        m_upd = 1'b0;
        repeat (100) @(negedge clk);
        m_text = {32{8'h7A}};
        m_upd = 1'b1;
        repeat (2000) @(negedge clk);
        m_upd = 1'b0;
        while (m_fd !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
        n_chk++; if (m_fd !== 1'b1) begin n_fail++; $display("FAIL busy_done: Frame_done=%b, want 1", m_fd); end
        for (int i = 0; i < 34 && 2 * i + 1 < mq.size(); i++) begin
            n_chk++; if ({mq[2*i], mq[2*i+1]} !== exp_pair("ABCDEFGHIJKLMNOP", "QRSTUVWXYZ012345", i)) begin n_fail++;
                $display("FAIL busy_byte%0d: %h, want %h", i, {mq[2*i], mq[2*i+1]}, exp_pair("ABCDEFGHIJKLMNOP", "QRSTUVWXYZ012345", i)); end
        end
        repeat (300) @(negedge clk);
        n_chk++; if (mq.size() !== 68) begin n_fail++; $display("FAIL busy_no_queue: %0d pulses, want 68", mq.size()); end
        n_chk++; if (fd_cnt - fdc !== 1) begin n_fail++; $display("FAIL busy_frames: %0d, want 1", fd_cnt - fdc); end
        n_chk++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL busy_ready: %b, want 1", m_ready); end
    endtask
    task automatic test_geometry();
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 20; c++) f_text[8*(80-r*20-c)-1 -: 8] = 8'(8'h41 + r * 20 + c);
        n_chk++; if (q1.size() < 12 || q1[4] !== 5'h02 || q1[5] !== 5'h00) begin n_fail++;
            $display("FAIL rows1_funcset: %0d pulses, nibbles %h %h, want 02 00", q1.size(), q1[4], q1[5]); end
        for (int i = 0; i < 20000 && f_ready !== 1'b1; i++) @(negedge clk);
        n_chk++; if (f_ready !== 1'b1) begin n_fail++; $display("FAIL geo_ready: %b, want 1", f_ready); end
        q4.delete();
        f_upd = 1'b1;
        @(negedge clk);
        f_upd = 1'b0;
        while (f_fd !== 1'b1 && n < 12000) begin @(negedge clk); n++; end
        n_chk++; if (n !== 10585) begin n_fail++; $display("FAIL geo_latency: %0d, want 10585", n); end
        n_chk++; if (q4.size() !== 168) begin n_fail++; $display("FAIL geo_count: %0d, want 168", q4.size()); end
        for (int i = 0; i < 84 && 2 * i + 1 < q4.size(); i++) begin
            automatic int r = i / 21;
            automatic int c = i % 21 - 1;
            automatic logic [7:0] b = c < 0 ? BASE4[r] : 8'(8'h41 + r * 20 + c);
            automatic logic rs = c >= 0;
            n_chk++; if ({q4[2*i], q4[2*i+1]} !== {rs, b[7:4], rs, b[3:0]}) begin n_fail++;
                $display("FAIL geo_byte%0d: %h, want %h", i, {q4[2*i], q4[2*i+1]}, {rs, b[7:4], rs, b[3:0]}); end
        end
    endtask
    task automatic test_clear();
        int fdc;
        m_text = "0123456789ABCDEFfedcba9876543210";
        @(negedge clk);
        m_upd = 1'b1;
        @(negedge clk);
        m_upd = 1'b0;
        repeat (480) @(negedge clk);
        fdc = fd_cnt;
        m_clr = 1'b1;
        @(negedge clk);
        m_clr = 1'b0;
        n_chk++; if ({m_ready, m_fd, m_e, m_rs, m_db, m_rw} !== 9'h0) begin n_fail++;
            $display("FAIL clear_outputs: %b, want 0", {m_ready, m_fd, m_e, m_rs, m_db, m_rw}); end
        mq.delete();
        for (int i = 0; i < 25000 && m_ready !== 1'b1; i++) @(negedge clk);
        n_chk++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready: %b, want 1", m_ready); end
        n_chk++; if (mq.size() !== 12) begin n_fail++; $display("FAIL clear_count: %0d pulses, want 12", mq.size()); end
        for (int i = 0; i < 12 && i < mq.size(); i++) begin
            n_chk++; if (mq[i] !== INIT_SEQ[i]) begin n_fail++; $display("FAIL clear_nib%0d: %h, want %h", i, mq[i], INIT_SEQ[i]); end
        end
        n_chk++; if (fd_cnt !== fdc) begin n_fail++; $display("FAIL clear_no_done: %0d pulses, want 0", fd_cnt - fdc); end
    endtask
    task automatic test_pins();
        n_chk++; if (rw_bad !== 0) begin n_fail++; $display("FAIL pins_rw: %0d bad cycles, want 0", rw_bad); end
        n_chk++; if (setup_bad !== 0) begin n_fail++; $display("FAIL pins_setup: %0d bad pulses, want 0", setup_bad); end
        n_chk++; if (width_bad !== 0) begin n_fail++; $display("FAIL pins_width: %0d bad pulses, want 0", width_bad); end
        n_chk++; if (hold_bad !== 0) begin n_fail++; $display("FAIL pins_hold: %0d bad pulses, want 0", hold_bad); end
    endtask
    initial begin
        repeat (3) @(negedge clk);
        m_clr = 1'b0;
        a_clr = 1'b0;
        test_timing();
        test_reset();
        test_frame();
        test_busy_update();
        test_geometry();
        test_clear();
        test_pins();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_hd44780_controller.md
# lcd_hd44780_controller

Parametrised HD44780 character-LCD controller driving the panel in 4-bit write-only mode. Supports COLS×ROWS geometries, derives all bus timing from CLK_HZ, and performs the power-on initialisation once after reset. After initialisation it redraws the panel from a snapshot of the text input only when requested, with a Ready/Update handshake and a Frame_done pulse. It sits between keyboard/text-formatting logic and the LCD header pins.

## Interface
- CLK_HZ, 100_000_000, clock frequency in Hz; all delays are computed from it.
- COLS, 16, characters per row; legal range 8..40.
- ROWS, 2, rows; legal values 1, 2, 4.
- POWERUP_US, 15000, wait after reset before the first init nibble; benches may shorten it.

- Clock_100MHz  input  1  system clock; all logic on the rising edge.
- Clear  input  1  synchronous, active-high reset.
- Text  input  ROWS*COLS*8  character codes; char (r,c) = Text[8*(ROWS*COLS-r*COLS-c)-1 -: 8], so row 0 col 0 is the top byte.
- Update  input  1  redraw request; sampled only while Ready=1.
- Ready  output  1  high only in IDLE.
- Frame_done  output  1  one-cycle pulse after the last character of a frame.
- LCD_DB  output  [7:4]  data nibble.
- LCD_E  output  1  enable strobe.
- LCD_RS  output  1  0 = command, 1 = data.
- LCD_RW  output  1  tied 0 (write only).

## Operation
- Reset: every output is 0, the FSM goes to PWR_WAIT, and the counter is cleared. A Clear asserted mid-frame aborts immediately and runs the full init again; the frame is not resumed.
- FSM sequence: PWR_WAIT (POWERUP_US) → INIT8_1 (nibble 0x3, then 4.1 ms) → INIT8_2 (0x3, 100 µs) → INIT8_3 (0x3, 40 µs) → INIT4 (0x2, 40 µs) → FUNC_SET → ENTRY_MODE (0x06) → DISP_ON (0x0C: cursor off, blink off) → CLEAR_DISP (0x01, 1.64 ms) → IDLE.
- FUNC_SET sends 0x28 when ROWS≥2 and 0x20 when ROWS=1.
- IDLE: Ready=1. When Update=1, Text is latched into an internal buffer on that edge and the FSM goes to SET_ADDR with row=0.
- SET_ADDR: sends 0x80|base[row], where base = 0x00, 0x40, 0x14, 0x54. Then WRITE_CHAR.
- WRITE_CHAR: sends buffer char (row,col) with RS=1, for col = 0..COLS-1. After the last column, row increments and the FSM returns to SET_ADDR. After the last row it goes to DONE.
- DONE: Frame_done=1 for exactly one cycle, then IDLE.
- Changes to Text during a frame do not affect that frame. Update while Ready=0 is ignored and is not queued.
- Nibble-only steps (INIT8_x, INIT4) drive RS=0 and the nibble on DB, with one E pulse.
- Byte steps send the high nibble, then the low nibble, then the post-command delay.

## Timing
- Derived cycle counts, using ceil(t·CLK_HZ); values at 100 MHz in brackets:
  - TSU = 40 ns [4]
  - TPW = 230 ns [23]
  - THD = 10 ns [1]
  - TNIB = 1 µs [100]
  - TCMD = 40 µs [4000]
  - TCLR = 1.64 ms [164000]
  - T41 = 4.1 ms [410000]
  - T100 = 100 µs [10000]
- Nibble cycle: RS/RW/DB become valid on cycle 0. E=1 on cycles TSU .. TSU+TPW-1. RS/DB are held through cycle TSU+TPW+THD-1 and then return to 0. The next nibble starts at cycle TNIB.
- The post-command delay is counted from the end of the low-nibble TNIB window.
- One counter sized $clog2 of the largest delay, reset to 0 at every step boundary. There are no combinational paths from inputs to LCD pins; all LCD outputs are registered.
- Frame latency from Update to Frame_done = ROWS*(COLS+1)*(2*TNIB+TCMD) + 1 cycles. At defaults: 34*4200+1 = 142801.

## Configuration
- LCD_AUTO_REFRESH_EN defined: IDLE behaves as if Update=1 every cycle. The panel is redrawn continuously, Frame_done pulses once per frame, and Ready still pulses high for one cycle per frame.
- Undefined: a redraw happens only on an Update accepted while Ready=1.

## Test plan
- Reset with POWERUP_US=10 → exactly 4 E pulses carrying DB=3,3,3,2, spaced ≥410000, 10000 and 4000 cycles; then 8 E pulses carrying 2,8,0,6,0,C,0,1; then Ready=1.
- Text = "HELLO WORLD 1234" / "KEYBOARD TEST OK", Update pulse → nibble decode gives 0x80, 16 chars, 0xC0, 16 chars. Frame_done rises exactly 142801 cycles after Update.
- Every E pulse → RS/DB stable ≥4 cycles before the E rise, E high exactly 23 cycles, data held 1 cycle after the E fall, and LCD_RW=0 throughout.
- Update held high while Ready=0 → no second frame. Text changed mid-frame → the old text is displayed.
- ROWS=4, COLS=20 → row addresses 0x80, 0xC0, 0x94, 0xD4, with 20 chars each. ROWS=1 → FUNC_SET nibbles 2,0.
- Clear asserted mid-frame → the next cycle has all outputs 0, and the full init sequence repeats before Ready=1.
